// File: rtl/stage_arb_pkg.sv
// Shared types and constants for the round-robin stage arbiter.
package stage_arb_pkg;

  typedef enum logic {IDLE, LOCKED} arb_state_t;

  typedef logic [15:0] xfer_cnt_t;

  localparam int RR_MAX_REQ = 8;
  // Burst counter width; holds BURST values up to 15.
  localparam int BEATS_W = 4;

  // Index width used by the round-robin search; never narrower than one bit.
  function automatic int rr_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search: first set request after start, with wrap,
// optionally skipping one index unless it is the only request present.
module rr_pick import stage_arb_pkg::*; #(
  parameter int N  = 4,
  parameter int IW = rr_idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  input  logic [IW-1:0] exclude_idx,
  input  logic          exclude_en,
  output logic          found,
  output logic [IW-1:0] index
);

  logic [N-1:0]  excl;
  logic [N-1:0]  cand;
  logic [IW-1:0] pos;

  // NOTE: every variable gets a default before any branch so no latch is inferred.
  always_comb begin
    excl  = '0;
    found = 1'b0;
    index = '0;
    pos   = '0;
    if (exclude_en) excl[exclude_idx] = 1'b1;
    cand = ((req & ~excl) != '0) ? (req & ~excl) : req;
    // Walk from farthest to nearest so the nearest hit is the last one written.
    for (int k = N; k >= 1; k--) begin
      pos = IW'((int'(start) + k) % N);
      if (cand[pos]) begin
        found = 1'b1;
        index = pos;
      end
    end
  end

endmodule

// File: rtl/stage_arbiter.sv
// Round-robin arbiter feeding one registered output stage, with per-owner
// burst locking and a wrapping count of accepted beats.
module stage_arbiter import stage_arb_pkg::*; #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int BURST = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*WIDTH-1:0]     req_data,
  output logic [N_REQ-1:0]           req_ready,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(N_REQ)-1:0]   out_id,
  input  logic                       out_ready,
  output logic [15:0]                xfer_cnt
);

  localparam int IW = rr_idx_w(N_REQ);

  arb_state_t         state, state_next;
  logic [IW-1:0]      ptr, ptr_next;
  logic [IW-1:0]      owner, owner_next;
  logic [BEATS_W-1:0] beats, beats_next;
  logic               load, regrant, take, found;
  logic [IW-1:0]      pick, win, search_start;
  logic [N_REQ-1:0]   grant;
  logic [WIDTH-1:0]   sel_data;
  xfer_cnt_t          cnt_next;

  // Leaving a lock restarts the search just after the old owner.
  assign search_start = (state == LOCKED) ? owner : ptr;

  rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
    .req         (req_valid),
    .start       (search_start),
    .exclude_idx (owner),
    .exclude_en  (state == LOCKED),
    .found       (found),
    .index       (pick)
  );

  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    owner_next = owner;
    beats_next = beats;
    take       = 1'b0;
    win        = owner;
    grant      = '0;
    load       = !out_valid || out_ready;
    regrant    = (state == LOCKED) && req_valid[owner] && (beats < BEATS_W'(BURST));
    if (load) begin
      if (regrant) begin
        take       = 1'b1;
        beats_next = beats + 1'b1;
      end else begin
        if (state == LOCKED) ptr_next = owner;
        if (found) begin
          take       = 1'b1;
          win        = pick;
          state_next = LOCKED;
          owner_next = pick;
          beats_next = BEATS_W'(1);
        end else begin
          state_next = IDLE;
          beats_next = '0;
        end
      end
    end
    if (take && !rst) grant[win] = 1'b1;
  end

  assign req_ready = grant;
  assign cnt_next  = xfer_cnt + 16'd1;

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win == IW'(i)) sel_data = req_data[i*WIDTH +: WIDTH];
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= IW'(N_REQ - 1);
      owner     <= '0;
      beats     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
      xfer_cnt  <= '0;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
      owner <= owner_next;
      beats <= beats_next;
      if (load) begin
        out_valid <= take;
        if (take) begin
          out_data <= sel_data;
          out_id   <= win;
          xfer_cnt <= cnt_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_stage_arbiter.sv
// Directed bench for stage_arbiter: a per-cycle vector table plus short
// sequences for burst rotation, sole requester, reset and counter wrap.
module tb_stage_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic        out_ready;

  logic [3:0]  ready2, ready1;
  logic        ov2, ov1;
  logic [7:0]  od2, od1;
  logic [1:0]  id2, id1;
  logic [15:0] cnt2, cnt1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  stage_arbiter #(.N_REQ(4), .WIDTH(8), .BURST(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(ready2), .out_valid(ov2), .out_data(od2), .out_id(id2),
    .out_ready(out_ready), .xfer_cnt(cnt2)
  );

  stage_arbiter #(.N_REQ(4), .WIDTH(8), .BURST(1)) dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(ready1), .out_valid(ov1), .out_data(od1), .out_id(id1),
    .out_ready(out_ready), .xfer_cnt(cnt1)
  );

  typedef struct {
    logic [3:0]  valid;
    logic        ordy;
    logic [3:0]  ready;
    logic        ov;
    logic [7:0]  data;
    logic [1:0]  id;
    logic [15:0] cnt;
  } vec_t;

  vec_t       vecs[11];
  logic [1:0] exp_b2[10];
  logic [1:0] exp_b1[6];
  logic [7:0] beat_of[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = 4'b0000;
    out_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{4'b0001, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0, 16'd1};
    vecs[1]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0, 16'd1};
    vecs[2]  = '{4'b0100, 1'b1, 4'b0100, 1'b1, 8'h33, 2'd2, 16'd2};
    vecs[3]  = '{4'b1000, 1'b0, 4'b0000, 1'b1, 8'h33, 2'd2, 16'd2};
    vecs[4]  = '{4'b1000, 1'b0, 4'b0000, 1'b1, 8'h33, 2'd2, 16'd2};
    vecs[5]  = '{4'b1000, 1'b0, 4'b0000, 1'b1, 8'h33, 2'd2, 16'd2};
    vecs[6]  = '{4'b1000, 1'b1, 4'b1000, 1'b1, 8'h44, 2'd3, 16'd3};
    vecs[7]  = '{4'b1001, 1'b1, 4'b1000, 1'b1, 8'h44, 2'd3, 16'd4};
    vecs[8]  = '{4'b1001, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0, 16'd5};
    vecs[9]  = '{4'b0000, 1'b0, 4'b0000, 1'b1, 8'h11, 2'd0, 16'd5};
    vecs[10] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0, 16'd5};
    exp_b2 = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0, 2'd0};
    exp_b1 = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    beat_of = '{8'h11, 8'h22, 8'h33, 8'h44};

    req_data  = {8'h44, 8'h33, 8'h22, 8'h11};
    rst       = 1'b1;
    req_valid = 4'b1111;
    out_ready = 1'b1;
    #1;
    check("ready_in_reset", 32'(ready2), 32'h0);
    step();
    check("rst_out_valid", 32'(ov2), 32'h0);
    check("rst_out_data", 32'(od2), 32'h0);
    check("rst_out_id", 32'(id2), 32'h0);
    check("rst_xfer_cnt", 32'(cnt2), 32'h0);
    req_valid = 4'b0000;
    step();
    rst = 1'b0;

    // Single requester, idle gap, backpressure hold and release, burst handover.
    for (int v = 0; v < 11; v++) begin
      req_valid = vecs[v].valid;
      out_ready = vecs[v].ordy;
      #1;
      check($sformatf("v%0d_ready", v), 32'(ready2), 32'(vecs[v].ready));
      step();
      check($sformatf("v%0d_out_valid", v), 32'(ov2), 32'(vecs[v].ov));
      if (vecs[v].ov) begin
        check($sformatf("v%0d_out_data", v), 32'(od2), 32'(vecs[v].data));
        check($sformatf("v%0d_out_id", v), 32'(id2), 32'(vecs[v].id));
      end
      check($sformatf("v%0d_xfer_cnt", v), 32'(cnt2), 32'(vecs[v].cnt));
    end

    // All requesters busy: BURST=2 pairs, BURST=1 pure rotation.
    do_reset();
    req_valid = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("rr2_id%0d", i), 32'(id2), 32'(exp_b2[i]));
      check($sformatf("rr2_data%0d", i), 32'(od2), 32'(beat_of[exp_b2[i]]));
      if (i < 6) check($sformatf("rr1_id%0d", i), 32'(id1), 32'(exp_b1[i]));
    end
    check("rr2_cnt10", 32'(cnt2), 32'd10);

    // Sole requester keeps being regranted past the burst limit.
    do_reset();
    req_valid = 4'b0100;
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("solo_ready%0d", i), 32'(ready2), 32'h4);
      step();
      check($sformatf("solo_id%0d", i), 32'(id2), 32'd2);
      check($sformatf("solo_valid%0d", i), 32'(ov2), 32'd1);
    end
    check("solo_cnt", 32'(cnt2), 32'd5);

    // Reset in the middle of a stream drops the in-flight beat.
    do_reset();
    req_valid = 4'b1111;
    for (int i = 0; i < 7; i++) step();
    check("mid_cnt7", 32'(cnt2), 32'd7);
    check("mid_valid", 32'(ov2), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_ready_rst", 32'(ready2), 32'h0);
    step();
    check("mid_rst_valid", 32'(ov2), 32'h0);
    check("mid_rst_cnt", 32'(cnt2), 32'h0);
    check("mid_rst_id", 32'(id2), 32'h0);
    rst = 1'b0;
    #1;
    check("mid_first_ready", 32'(ready2), 32'h1);
    step();
    check("mid_first_id", 32'(id2), 32'd0);
    check("mid_first_data", 32'(od2), 32'h11);

    // Counter wraps from 0xFFFF to 0x0000.
    do_reset();
    force dut.xfer_cnt = 16'hFFFE;
    #1;
    release dut.xfer_cnt;
    req_valid = 4'b0001;
    step();
    check("wrap_ffff", 32'(cnt2), 32'hFFFF);
    step();
    check("wrap_0000", 32'(cnt2), 32'h0000);
    step();
    check("wrap_0001", 32'(cnt2), 32'h0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
